// File: rtl/decode_stage.sv
// ============================================================================
// decode_stage : MIPS decode pipeline register, instruction decode, branch resolve
// Revision 1.0
// ============================================================================
`default_nettype none

module decode_stage #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        fe_valid,
  input  logic [31:0] fe_pc,
  input  logic [31:0] fe_inst,
  input  logic        exe_allowin,
  output logic        de_allowin,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  output logic        br_taken,
  output logic [31:0] br_target,
  output logic        de_valid,
  output logic [31:0] de_pc,
  output logic [11:0] de_alu_op,
  output logic [31:0] de_src1,
  output logic [31:0] de_src2,
  output logic [4:0]  de_dest,
  output logic        de_rf_we,
  output logic        de_mem_en,
  output logic        de_mem_we,
  output logic [31:0] de_st_data,
  output logic        de_ri
);

  localparam logic [11:0] ALU_ADD  = 12'h001;
  localparam logic [11:0] ALU_SUB  = 12'h002;
  localparam logic [11:0] ALU_SLT  = 12'h004;
  localparam logic [11:0] ALU_SLTU = 12'h008;
  localparam logic [11:0] ALU_AND  = 12'h010;
  localparam logic [11:0] ALU_NOR  = 12'h020;
  localparam logic [11:0] ALU_OR   = 12'h040;
  localparam logic [11:0] ALU_XOR  = 12'h080;
  localparam logic [11:0] ALU_SLL  = 12'h100;
  localparam logic [11:0] ALU_SRL  = 12'h200;
  localparam logic [11:0] ALU_SRA  = 12'h400;
  localparam logic [11:0] ALU_LUI  = 12'h800;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0a;
  localparam logic [5:0] OP_SLTIU   = 6'h0b;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2a;
  localparam logic [5:0] F_SLTU = 6'h2b;

  logic        de_valid_q, de_valid_d;
  logic [31:0] de_pc_q,    de_pc_d;
  logic [31:0] de_inst_q,  de_inst_d;

  assign de_allowin = !de_valid_q || exe_allowin;

  always_comb begin
    de_valid_d = de_valid_q;
    de_pc_d    = de_pc_q;
    de_inst_d  = de_inst_q;
    if (de_allowin) begin
      de_valid_d = fe_valid;
      de_pc_d    = fe_pc;
      de_inst_d  = fe_inst;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      de_valid_q <= 1'b0;
      de_pc_q    <= RESET_PC;
      de_inst_q  <= 32'h0;
    end else begin
      de_valid_q <= de_valid_d;
      de_pc_q    <= de_pc_d;
      de_inst_q  <= de_inst_d;
    end
  end

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  sa;
  logic [15:0] imm;
  logic [31:0] simm;
  logic [31:0] zimm;
  logic [31:0] pc4;
  logic [31:0] br_off_target;
  logic [31:0] jmp_target;

  assign opcode = de_inst_q[31:26];
  assign rs     = de_inst_q[25:21];
  assign rt     = de_inst_q[20:16];
  assign rd     = de_inst_q[15:11];
  assign sa     = de_inst_q[10:6];
  assign funct  = de_inst_q[5:0];
  assign imm    = de_inst_q[15:0];
  assign simm   = {{16{imm[15]}}, imm};
  assign zimm   = {16'h0, imm};
  assign pc4    = de_pc_q + 32'd4;
  assign br_off_target = pc4 + {{14{imm[15]}}, imm, 2'b00};
  assign jmp_target    = {pc4[31:28], de_inst_q[25:0], 2'b00};

  logic [11:0] alu_op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [4:0]  dest;
  logic        rf_we;
  logic        mem_en;
  logic        mem_we;
  logic        ri;
  logic        taken;
  logic [31:0] target;

  always_comb begin
    alu_op = '0;
    src1   = rf_rdata1;
    src2   = rf_rdata2;
    dest   = rd;
    rf_we  = 1'b0;
    mem_en = 1'b0;
    mem_we = 1'b0;
    ri     = 1'b0;
    taken  = 1'b0;
    target = br_off_target;
    case (opcode)
      OP_SPECIAL: begin
        case (funct)
          F_ADDU: begin alu_op = ALU_ADD;  rf_we = 1'b1; end
          F_SUBU: begin alu_op = ALU_SUB;  rf_we = 1'b1; end
          F_SLT:  begin alu_op = ALU_SLT;  rf_we = 1'b1; end
          F_SLTU: begin alu_op = ALU_SLTU; rf_we = 1'b1; end
          F_AND:  begin alu_op = ALU_AND;  rf_we = 1'b1; end
          F_OR:   begin alu_op = ALU_OR;   rf_we = 1'b1; end
          F_XOR:  begin alu_op = ALU_XOR;  rf_we = 1'b1; end
          F_NOR:  begin alu_op = ALU_NOR;  rf_we = 1'b1; end
          // Shift amount comes from the sa field, shifted value from rt
          F_SLL:  begin alu_op = ALU_SLL; src1 = {27'b0, sa}; rf_we = 1'b1; end
          F_SRL:  begin alu_op = ALU_SRL; src1 = {27'b0, sa}; rf_we = 1'b1; end
          F_SRA:  begin alu_op = ALU_SRA; src1 = {27'b0, sa}; rf_we = 1'b1; end
          F_JR:   begin taken = 1'b1; target = rf_rdata1; end
          default: ri = 1'b1;
        endcase
      end
      OP_ADDIU: begin alu_op = ALU_ADD;  src2 = simm; dest = rt; rf_we = 1'b1; end
      OP_SLTI:  begin alu_op = ALU_SLT;  src2 = simm; dest = rt; rf_we = 1'b1; end
      OP_SLTIU: begin alu_op = ALU_SLTU; src2 = simm; dest = rt; rf_we = 1'b1; end
      OP_ANDI:  begin alu_op = ALU_AND;  src2 = zimm; dest = rt; rf_we = 1'b1; end
      OP_ORI:   begin alu_op = ALU_OR;   src2 = zimm; dest = rt; rf_we = 1'b1; end
      OP_XORI:  begin alu_op = ALU_XOR;  src2 = zimm; dest = rt; rf_we = 1'b1; end
      OP_LUI:   begin alu_op = ALU_LUI;  src2 = {imm, 16'h0}; dest = rt; rf_we = 1'b1; end
      OP_LW: begin
        alu_op = ALU_ADD; src2 = simm; dest = rt; rf_we = 1'b1; mem_en = 1'b1;
      end
      OP_SW: begin
        alu_op = ALU_ADD; src2 = simm; dest = rt; mem_en = 1'b1; mem_we = 1'b1;
      end
      OP_BEQ: begin dest = rt; taken = (rf_rdata1 == rf_rdata2); end
      OP_BNE: begin dest = rt; taken = (rf_rdata1 != rf_rdata2); end
      OP_J:   begin taken = 1'b1; target = jmp_target; end
      // Link value pc+8 is formed by the execute adder
      OP_JAL: begin
        taken  = 1'b1;
        target = jmp_target;
        alu_op = ALU_ADD;
        src1   = de_pc_q;
        src2   = 32'd8;
        dest   = 5'd31;
        rf_we  = 1'b1;
      end
      default: ri = 1'b1;
    endcase
  end

  assign rf_raddr1  = rs;
  assign rf_raddr2  = rt;
  assign de_valid   = de_valid_q;
  assign de_pc      = de_pc_q;
  assign de_src1    = src1;
  assign de_src2    = src2;
  assign de_dest    = dest;
  assign de_st_data = rf_rdata2;
  assign br_target  = target;

  // Controls are squashed for a bubble so execute never acts on stale state
  assign de_alu_op = de_valid_q ? alu_op : 12'h000;
  assign de_rf_we  = de_valid_q && rf_we;
  assign de_mem_en = de_valid_q && mem_en;
  assign de_mem_we = de_valid_q && mem_we;
  assign de_ri     = de_valid_q && ri;
  assign br_taken  = de_valid_q && taken;

endmodule

`default_nettype wire

// File: doc/decode_stage.md
# decode_stage

Second pipeline stage of the 5-stage MIPS core. Registers the PC/instruction pair produced by the fetch stage and decodes it into execute-stage controls and operands. Drives the register-file read ports and resolves branches/jumps (delay-slot semantics) back to next-PC logic. Holds its contents under back-pressure from execute.

## Interface
- RESET_PC, 32'hbfc00000, value of de_pc while reset is asserted
- clk  in  1  clock; all state on rising edge
- resetn  in  1  synchronous, active-low reset
- fe_valid  in  1  fe_pc/fe_inst hold a real instruction
- fe_pc  in  32  fetch-stage PC
- fe_inst  in  32  fetch-stage instruction word
- exe_allowin  in  1  execute can accept an instruction this cycle
- de_allowin  out  1  decode can accept a new instruction this cycle
- rf_raddr1, rf_raddr2  out  5  register-file read addresses (rs, rt)
- rf_rdata1, rf_rdata2  in  32  register-file read data, bypassed externally
- br_taken  out  1  redirect next-PC this cycle
- br_target  out  32  redirect address
- de_valid  out  1  decode outputs hold a valid instruction for execute
- de_pc  out  32  registered PC
- de_alu_op  out  12  one-hot: add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui
- de_src1, de_src2  out  32  ALU operands
- de_dest  out  5  destination register
- de_rf_we, de_mem_en, de_mem_we  out  1  writeback / memory controls
- de_st_data  out  32  store data (rt value)
- de_ri  out  1  reserved (undecodable) instruction

## Operation
- Pipeline register {de_valid_r, de_pc, de_inst} loads when de_allowin=1: de_valid_r<=fe_valid, de_pc<=fe_pc, de_inst<=fe_inst. Otherwise holds.
- de_allowin = !de_valid_r || exe_allowin (decode ready_go is always 1). de_valid = de_valid_r.
- Supported: ADDU SUBU SLT SLTU AND OR XOR NOR SLL SRL SRA JR; ADDIU SLTI SLTIU ANDI ORI XORI LUI LW SW BEQ BNE J JAL. Anything else: de_ri=1, de_rf_we=de_mem_en=de_mem_we=0, all alu_op bits 0.
- Operands: rf_raddr1=inst[25:21], rf_raddr2=inst[20:16] always.
  - R-type: src1=rs, src2=rt, dest=rd. Shifts: src1={27'b0,sa}, src2=rt.
  - ADDIU/SLTI/SLTIU/LW/SW: src2=sign-extended imm; ANDI/ORI/XORI: zero-extended; LUI: src2={imm,16'b0}, op lui. I-type dest=rt.
  - LW: add, mem_en=1, rf_we=1. SW: add, mem_en=1, mem_we=1, rf_we=0, st_data=rt.
  - JAL: op add, src1=de_pc, src2=8, dest=31, rf_we=1. J/JR/BEQ/BNE: rf_we=0.
- Branch: BEQ taken iff rdata1==rdata2; BNE iff !=. target=de_pc+4+(sext(imm)<<2). J/JAL: {pc4[31:28],inst[25:0],2'b00}. JR: rdata1. All sums mod 2^32.
- br_taken = de_valid_r && taken. Delay slot executes normally; no flush.
- When de_valid_r=0, every control output (rf_we, mem_en, mem_we, alu_op, ri, br_taken) is 0; data outputs are don't-care.
- Writes to $0 are legal at decode; de_rf_we is not suppressed for dest=0.

## Timing
- Reset (resetn=0 at a clock edge): de_valid_r=0, de_pc=RESET_PC, de_inst=0. Reset overrides any load. Outputs after reset: de_valid=0, de_allowin=1, br_taken=0.
- Latency: instruction presented with de_allowin=1 appears at decode outputs 1 cycle later.
- Decode, operand selection and branch resolution are combinational from the registered word and rf_rdata, same cycle.
- Stall: exe_allowin=0 with de_valid_r=1 → de_allowin=0; register and br_taken/br_target held stable until exe_allowin=1.
- fe_valid=0 while de_allowin=1 inserts a bubble (de_valid_r<=0).

## Test plan
- Reset: resetn=0 two cycles → de_valid=0, de_pc=bfc00000, de_allowin=1, br_taken=0.
- ADDIU $2,$1,-1 (0x2422ffff) at pc bfc00000, exe_allowin=1 → next cycle de_alu_op=add, src2=ffffffff, dest=2, rf_we=1, rf_raddr1=1.
- BEQ taken, pc=bfc00010, imm=0xfffe, rdata1=rdata2=5 → br_taken=1, br_target=bfc0000c; rdata2=6 → br_taken=0.
- JAL 0x0100000 at pc bfc00020 → br_target=b0400000, dest=31, src1=bfc00020, src2=8, rf_we=1.
- Stall: LW decoded, exe_allowin=0 for 3 cycles while fetch changes → de_pc/outputs unchanged, de_allowin=0; release → next fetch word loaded.
- Unknown opcode 0xfc000000 → de_ri=1, rf_we=mem_en=0; fe_valid=0 cycle → de_valid=0, all controls 0.
